// File: rtl/pulse_timing_monitor_pkg.sv
// Shared types and constants for the pixel control waveform timing monitor.
// Channel indices follow the bit order of sig_in / chan_en.
package pulse_timing_monitor_pkg;

    localparam int NCH_DEF = 7;
    localparam int CW_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEAS = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int CH_VD1      = 0;
    localparam int CH_VD2      = 1;
    localparam int CH_SW1      = 2;
    localparam int CH_SW2      = 3;
    localparam int CH_SH       = 4;
    localparam int CH_SH_CMP   = 5;
    localparam int CH_SH_RESET = 6;

endpackage

// File: rtl/pulse_timing_monitor_edge_capture.sv
// Per-channel first-pulse capture: rise time and high duration of the
// first complete pulse seen after the last clear.
module pulse_timing_monitor_edge_capture
    import pulse_timing_monitor_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          meas,
    input  logic          sig,
    input  logic [CW-1:0] cnt,
    output logic [CW-1:0] rise,
    output logic [CW-1:0] high,
    output logic          got_rise,
    output logic          got_fall
);

    logic          prev_q, prev_d;
    logic [CW-1:0] rise_q, rise_d;
    logic [CW-1:0] high_q, high_d;
    logic          got_rise_q, got_rise_d;
    logic          got_fall_q, got_fall_d;

    always_comb begin
        prev_d     = sig;
        rise_d     = rise_q;
        high_d     = high_q;
        got_rise_d = got_rise_q;
        got_fall_d = got_fall_q;
        if (clear) begin
            rise_d     = '0;
            high_d     = '0;
            got_rise_d = 1'b0;
            got_fall_d = 1'b0;
        end else if (meas) begin
            if (!got_rise_q && sig && !prev_q) begin
                rise_d     = cnt;
                got_rise_d = 1'b1;
            end
            // a fall only counts once its rise is registered, so a level
            // that was already high at arm never produces a pulse
            if (got_rise_q && !got_fall_q && !sig && prev_q) begin
                high_d     = cnt - rise_q;
                got_fall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= 1'b0;
            rise_q     <= '0;
            high_q     <= '0;
            got_rise_q <= 1'b0;
            got_fall_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            rise_q     <= rise_d;
            high_q     <= high_d;
            got_rise_q <= got_rise_d;
            got_fall_q <= got_fall_d;
        end
    end

    assign rise     = rise_q;
    assign high     = high_q;
    assign got_rise = got_rise_q;
    assign got_fall = got_fall_q;

endmodule

// File: rtl/pulse_timing_monitor.sv
// Receive-side timing checker: arms on start, measures first pulse per
// channel against a local counter, and exposes results through a sel mux.
module pulse_timing_monitor
    import pulse_timing_monitor_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [NCH-1:0] chan_en,
    input  logic [NCH-1:0] sig_in,
    input  logic [2:0]     sel,
    output logic           busy,
    output logic           valid,
    output logic           timeout,
    output logic [CW-1:0]  rd_rise,
    output logic [CW-1:0]  rd_high,
    output logic [1:0]     rd_flags
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] en_q, en_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic [CW-1:0]  rd_rise_q, rd_rise_d;
    logic [CW-1:0]  rd_high_q, rd_high_d;
    logic [1:0]     rd_flags_q, rd_flags_d;

    logic [CW-1:0]  rise_w [NCH];
    logic [CW-1:0]  high_w [NCH];
    logic [NCH-1:0] got_rise_w;
    logic [NCH-1:0] got_fall_w;
    logic           meas;
    logic           complete;

    assign meas     = (state_q == MEAS) && !start;
    assign complete = ((got_fall_w & en_q) == en_q);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_timing_monitor_edge_capture #(
            .CW(CW)
        ) u_edge_capture (
            .clk      (clk),
            .reset    (reset),
            .clear    (start),
            .meas     (meas),
            .sig      (sig_in[i]),
            .cnt      (cnt_q),
            .rise     (rise_w[i]),
            .high     (high_w[i]),
            .got_rise (got_rise_w[i]),
            .got_fall (got_fall_w[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        if (start) begin
            state_d   = MEAS;
            cnt_d     = '0;
            en_d      = chan_en;
            busy_d    = 1'b1;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == MEAS) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (complete) begin
                state_d = DONE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                state_d   = DONE;
                busy_d    = 1'b0;
                valid_d   = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_rise_d  = '0;
        rd_high_d  = '0;
        rd_flags_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == 3'(i)) begin
                rd_rise_d  = rise_w[i];
                rd_high_d  = high_w[i];
                rd_flags_d = {got_fall_w[i], got_rise_w[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            en_q       <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            rd_rise_q  <= '0;
            rd_high_q  <= '0;
            rd_flags_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            rd_rise_q  <= rd_rise_d;
            rd_high_q  <= rd_high_d;
            rd_flags_q <= rd_flags_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign rd_rise  = rd_rise_q;
    assign rd_high  = rd_high_q;
    assign rd_flags = rd_flags_q;

endmodule

// File: tb/tb_pulse_timing_monitor.sv
// Scoreboard bench for pulse_timing_monitor: waveforms are described as
// toggle lists, expected results derived from the pulse rules directly.
module tb_pulse_timing_monitor;

    localparam int NCH  = 7;
    localparam int CW   = 12;
    localparam int MAXC = 4095;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [NCH-1:0] chan_en;
    logic [NCH-1:0] sig_in;
    logic [2:0]     sel;
    logic           busy;
    logic           valid;
    logic           timeout;
    logic [CW-1:0]  rd_rise;
    logic [CW-1:0]  rd_high;
    logic [1:0]     rd_flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pulse_timing_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .chan_en  (chan_en),
        .sig_in   (sig_in),
        .sel      (sel),
        .busy     (busy),
        .valid    (valid),
        .timeout  (timeout),
        .rd_rise  (rd_rise),
        .rd_high  (rd_high),
        .rd_flags (rd_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit to;
    } done_t;

    typedef struct {
        int due;
        int s;
        int r;
        int h;
        int fl;
    } rd_t;

    done_t done_q[$];
    rd_t   rd_q[$];

    // waveform description: level at MEAS edge k
    bit init_l [NCH];
    int ntog   [NCH];
    int tog    [NCH][6];

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic bit level(int ch, int k);
        int n = 0;
        for (int j = 0; j < ntog[ch]; j++)
            if (tog[ch][j] <= k) n++;
        return init_l[ch] ^ n[0];
    endfunction

    function automatic logic [NCH-1:0] level_vec(int k);
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = level(ch, k);
        return v;
    endfunction

    function automatic void first_pulse(int ch, output int r, output int f);
        int lim = 0;
        bit cur, prv;
        r = -1;
        f = -1;
        for (int j = 0; j < ntog[ch]; j++)
            if (tog[ch][j] + 1 > lim) lim = tog[ch][j] + 1;
        if (lim > MAXC) lim = MAXC;
        for (int k = 0; k <= lim; k++) begin
            cur = level(ch, k);
            prv = (k == 0) ? init_l[ch] : level(ch, k - 1);
            if (r < 0) begin
                if (cur && !prv) r = k;
            end else if (f < 0 && !cur && prv) begin
                f = k;
            end
        end
    endfunction

    task automatic clr();
        for (int ch = 0; ch < NCH; ch++) begin
            init_l[ch] = 1'b0;
            ntog[ch]   = 0;
        end
    endtask

    task automatic run(input logic [NCH-1:0] en, input int abort_k);
        int r [NCH];
        int f [NCH];
        int e, mx, last, base;
        bit to, all;
        logic [NCH-1:0] iv;
        rd_t x;
        for (int ch = 0; ch < NCH; ch++) first_pulse(ch, r[ch], f[ch]);
        mx  = 0;
        all = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (en[ch]) begin
                if (f[ch] < 0 || f[ch] > MAXC - 1) all = 1'b0;
                else if (f[ch] > mx) mx = f[ch];
            end
        end
        if (en == '0) begin
            e = 0; to = 1'b0;
        end else if (all) begin
            e = mx + 1; to = 1'b0;
        end else begin
            e = MAXC; to = 1'b1;
        end
        for (int ch = 0; ch < NCH; ch++) iv[ch] = init_l[ch];
        @(negedge clk);
        start   = 1'b1;
        chan_en = en;
        sig_in  = iv;
        base    = cyc;
        if (abort_k < 0) done_q.push_back('{due: base + 2 + e, to: to});
        last = (abort_k < 0) ? e + 3 : abort_k - 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            start  = 1'b0;
            sig_in = level_vec(k);
        end
        if (abort_k >= 0) return;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            sel  = 3'(s);
            x.due = cyc + 1;
            x.s   = s;
            x.r   = 0;
            x.h   = 0;
            x.fl  = 0;
            if (s < NCH && r[s] >= 0 && r[s] <= e) begin
                x.r  = r[s];
                x.fl = 1;
                if (f[s] >= 0 && f[s] <= e) begin
                    x.h  = f[s] - r[s];
                    x.fl = 3;
                end
            end
            rd_q.push_back(x);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    bit pv = 1'b0;
    always @(negedge clk) begin
        rd_t   x;
        done_t d;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            x = rd_q.pop_front();
            chk($sformatf("rd_rise_s%0d", x.s), int'(rd_rise), x.r);
            chk($sformatf("rd_high_s%0d", x.s), int'(rd_high), x.h);
            chk($sformatf("rd_flags_s%0d", x.s), int'(rd_flags), x.fl);
        end
        if (valid && !pv) begin
            if (done_q.size() == 0) begin
                chk("valid_unexpected", 1, 0);
            end else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.due);
                chk("done_timeout", int'(timeout), int'(d.to));
                chk("done_busy", int'(busy), 0);
            end
        end else if (done_q.size() > 0 && cyc > done_q[0].due) begin
            chk("valid_missing", 0, 1);
            void'(done_q.pop_front());
        end
        pv <= valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] en;
        int r, f, t;
        reset   = 1'b1;
        start   = 1'b0;
        chan_en = '0;
        sig_in  = '0;
        sel     = '0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_rd_rise", int'(rd_rise), 0);
        chk("rst_rd_high", int'(rd_high), 0);
        chk("rst_rd_flags", int'(rd_flags), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        clr();
        tog[0][0:1] = '{10, 30}; ntog[0] = 2;
        run(7'h01, -1);

        clr();
        tog[0][0:1] = '{0, 100}; ntog[0] = 2;
        tog[1][0:1] = '{5, 25};  ntog[1] = 2;
        tog[2][0:1] = '{12, 20}; ntog[2] = 2;
        tog[3][0:1] = '{30, 90}; ntog[3] = 2;
        tog[4][0:1] = '{40, 55}; ntog[4] = 2;
        tog[5][0:1] = '{60, 61}; ntog[5] = 2;
        tog[6][0:1] = '{70, 80}; ntog[6] = 2;
        run(7'h7F, -1);

        clr();
        tog[1][0] = 5; ntog[1] = 1;
        run(7'h02, -1);

        clr();
        init_l[2] = 1'b1;
        tog[2][0:2] = '{3, 8, 12}; ntog[2] = 3;
        run(7'h04, -1);

        // restart mid-pulse, then continue from a pre-high level
        clr();
        tog[0][0] = 10; ntog[0] = 1;
        run(7'h01, 50);
        clr();
        init_l[0] = 1'b1;
        tog[0][0:2] = '{3, 8, 12}; ntog[0] = 3;
        run(7'h01, -1);

        clr();
        tog[0][0:1] = '{2, 6}; ntog[0] = 2;
        tog[1][0] = 3; ntog[1] = 1;
        sel = 3'd0;
        run(7'h03, 20);
        @(negedge clk);
        chk("pre_reset_rise", int'(rd_rise), 2);
        chk("pre_reset_high", int'(rd_high), 4);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("areset_busy", int'(busy), 0);
        chk("areset_valid", int'(valid), 0);
        chk("areset_rd_rise", int'(rd_rise), 0);
        chk("areset_rd_high", int'(rd_high), 0);
        chk("areset_rd_flags", int'(rd_flags), 0);
        @(negedge clk);
        reset = 1'b0;

        clr();
        tog[3][0:1] = '{0, 2}; ntog[3] = 2;
        run(7'h00, -1);

        for (int n = 0; n < 25; n++) begin
            clr();
            for (int ch = 0; ch < NCH; ch++) begin
                init_l[ch] = 1'($urandom % 2);
                ntog[ch]   = $urandom_range(0, 4);
                t = $urandom_range(0, 15);
                for (int j = 0; j < ntog[ch]; j++) begin
                    tog[ch][j] = t;
                    t += $urandom_range(1, 30);
                end
            end
            en = 7'($urandom % 128);
            for (int ch = 0; ch < NCH; ch++) begin
                first_pulse(ch, r, f);
                if (f < 0) en[ch] = 1'b0;
            end
            run(en, -1);
        end

        repeat (3) @(negedge clk);
        chk("done_q_drained", done_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_timing_monitor.md
Name: pulse_timing_monitor

Overview:
- Receive-side checker for the pixel control waveforms (vd1, vd2, sw1, sw2, sh, sh_cmp, sh_reset) produced by the timing FSMs.
- Once armed, a local cycle counter runs; for each channel the block captures the first rising-edge time and the high duration (fall minus rise).
- Results are read back through a channel-select mux for BIST and for calibrating the time_up/time_down programming.

Parameters:
- NCH, 7, number of monitored channels. Bit order: 0=vd1, 1=vd2, 2=sw1, 3=sw2, 4=sh, 5=sh_cmp, 6=sh_reset.
- CW, 12, counter and result width (matches the 12-bit timing counter).

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle arm/re-arm pulse.
- chan_en  in  NCH  channels that must complete before done; sampled at arm.
- sig_in  in  NCH  monitored waveforms.
- sel  in  3  readout channel select; values >= NCH read as zero.
- busy  out  1  high while in MEAS.
- valid  out  1  high in DONE.
- timeout  out  1  high when the window ended at counter saturation.
- rd_rise  out  CW  captured rise time of channel sel.
- rd_high  out  CW  captured high time of channel sel.
- rd_flags  out  2  {got_fall, got_rise} of channel sel.

Behaviour:
- Reset: state=IDLE. cnt, prev, en_q, all per-channel captures and flags are 0. busy=valid=timeout=0. rd_* = 0.
- States:
  - IDLE: wait for start.
  - MEAS: measuring.
  - DONE: results held until the next start.
- Arm (start in any state):
  - cnt<=0, prev<=sig_in, en_q<=chan_en.
  - Clear all captures, flags, valid and timeout.
  - state<=MEAS.
  - start in MEAS restarts the measurement; start in DONE re-arms.
- MEAS, every clock edge, per channel i (edge detection uses prev vs sig_in; prev<=sig_in every cycle):
  - Rise: !got_rise[i] && sig_in[i] && !prev[i] -> rise[i]<=cnt, got_rise[i]<=1.
  - Fall: got_rise[i] && !got_fall[i] && !sig_in[i] && prev[i] -> high[i]<=cnt-rise[i] (CW-bit subtract), got_fall[i]<=1.
  - Only the first pulse per channel is captured; later edges are ignored.
  - A signal already high at arm is not a rise; its first falling edge is ignored because got_rise=0.
  - A rise seen on the first MEAS edge reports rise=0.
  - Then cnt<=cnt+1.
- MEAS exit (priority top-down, evaluated on the registered flags):
  1. start: re-arm, as above.
  2. (got_fall & en_q) == en_q: -> DONE, valid=1. With en_q==0 this occurs on the first MEAS edge.
  3. cnt == 2^CW-1: -> DONE, valid=1, timeout=1. cnt does not wrap. Captures made on this same edge are kept.
- A fall and the completion check on the same edge: the completion check sees the flag one cycle later, so DONE is entered on the edge after the last fall.
- sig_in is ignored in IDLE and DONE.
- Readout: rd_* are registered mux outputs of channel sel (1-cycle latency), valid in every state. Readback while busy returns partial captures.
- Async reset mid-measure: immediate return to reset values; no result is retained.

Decomposition:
- Shared package:
  - State encoding IDLE=2'b00, MEAS=2'b01, DONE=2'b10.
  - Channel index constants CH_VD1..CH_SH_RESET.
  - CW default.
- Sub-module edge_capture: one instance per channel.
  - Inputs: clk, reset, clear, meas, sig, cnt.
  - Holds prev, rise, high, got_rise, got_fall.
  - Top level holds the FSM, cnt, en_q and the readout mux.

Test Plan:
- Single pulse: chan_en=7'h01; start; sig_in[0] rises on MEAS edge 10 and falls on edge 30 -> rd_rise=10, rd_high=20, rd_flags=2'b11; valid on edge 31; timeout=0.
- All channels: drive vd1 1 from 0 for 100 and sh 1 from 40 for 15 (other channels staggered) with chan_en=7'h7F -> per-sel readback matches each programmed rise/high; valid after the last fall.
- Timeout: chan_en=7'h02; sig_in[1] rises at 5 and never falls -> DONE at cnt=4095 with timeout=1, rd_flags=2'b01, rd_rise=5.
- Pre-high signal: sig_in[2]=1 at arm, falls at 3, rises at 8, falls at 12 -> rd_rise=8, rd_high=4.
- Restart and reset: start again at cnt=50 mid-pulse -> flags cleared, cnt restarts at 0. Assert reset for one cycle in MEAS -> busy, valid and rd_* return to 0 asynchronously.
- Empty mask: chan_en=0; start -> valid on the first MEAS edge, timeout=0. sel=7 reads all zeros.
